// File: rtl/sound_wave_sequencer_if.sv
// Audio sequencer bundle: Timer3/sound register fields in,
// square wave and PCM sample stream out.
interface sound_wave_sequencer_if;
  logic        timer_tick;
  logic        timer_run;
  logic [15:0] preset;
  logic [15:0] pivot;
  logic        preset_load;
  logic [2:0]  sound_control;
  logic [2:0]  sound_volume;
  logic        wave_out;
  logic        period_end;
  logic [7:0]  sample;
  logic        sample_valid;

  modport master (
    output timer_tick, timer_run, preset, pivot, preset_load,
    output sound_control, sound_volume,
    input  wave_out, period_end, sample, sample_valid
  );

  modport slave (
    input  timer_tick, timer_run, preset, pivot, preset_load,
    input  sound_control, sound_volume,
    output wave_out, period_end, sample, sample_valid
  );
endinterface

// File: rtl/sound_wave_sequencer.sv
// Timer3 preset/pivot square-wave generator with volume gating
// and box-filter decimation into 8-bit PCM samples.
module sound_wave_sequencer #(
  parameter int unsigned SAMPLE_DIV = 64,
  parameter logic [7:0]  AMP_FULL   = 8'd255,
  parameter logic [7:0]  AMP_HALF   = 8'd128
) (
  input logic              clk,
  input logic              reset,
  sound_wave_sequencer_if.slave snd
);
  localparam int unsigned LW = $clog2(SAMPLE_DIV);
  localparam int unsigned HW = LW + 1;
  localparam int unsigned PW = 8 + LW + 1;
  localparam logic [LW-1:0] WIN_LAST = LW'(SAMPLE_DIV - 1);

  logic [15:0]   counter_q, counter_d;
  logic [15:0]   stage_preset_q, stage_preset_d;
  logic [15:0]   stage_pivot_q, stage_pivot_d;
  logic [15:0]   act_preset_q, act_preset_d;
  logic [15:0]   act_pivot_q, act_pivot_d;
  logic          pending_q, pending_d;
  logic          wave_q, wave_d;
  logic          pend_q, pend_d;
  logic [7:0]    sample_q, sample_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] win_q, win_d;
  logic [HW-1:0] hits_q, hits_d;

  logic [7:0]    amp;
  logic [HW-1:0] hits_inc;
  logic [PW-1:0] prod;
  logic          win_end;

  always_comb begin
    counter_d      = counter_q;
    stage_preset_d = stage_preset_q;
    stage_pivot_d  = stage_pivot_q;
    act_preset_d   = act_preset_q;
    act_pivot_d    = act_pivot_q;
    pending_d      = pending_q;
    pend_d         = 1'b0;

    if (snd.preset_load) begin
      stage_preset_d = snd.preset;
      stage_pivot_d  = snd.pivot;
      pending_d      = 1'b1;
    end

    // A load in the same cycle as a reload bypasses the stage regs.
    if (!snd.timer_run) begin
      counter_d    = snd.preset_load ? snd.preset : stage_preset_q;
      act_preset_d = snd.preset_load ? snd.preset : stage_preset_q;
      act_pivot_d  = snd.preset_load ? snd.pivot  : stage_pivot_q;
      pending_d    = 1'b0;
    end else if (snd.timer_tick) begin
      if (counter_q != 16'd0) begin
        counter_d = counter_q - 16'd1;
      end else begin
        pend_d    = 1'b1;
        pending_d = 1'b0;
        unique case (1'b1)
          snd.preset_load: begin
            act_preset_d = snd.preset;
            act_pivot_d  = snd.pivot;
          end
          pending_q: begin
            act_preset_d = stage_preset_q;
            act_pivot_d  = stage_pivot_q;
          end
          default: begin
            act_preset_d = act_preset_q;
            act_pivot_d  = act_pivot_q;
          end
        endcase
        counter_d = act_preset_d;
      end
    end

    wave_d = snd.timer_run && (counter_q < act_pivot_q);
  end

  always_comb begin
    amp = 8'd0;
    if (snd.sound_control[1:0] == 2'd0) begin
      unique case (snd.sound_volume[1:0])
        2'd1, 2'd2: amp = AMP_HALF;
        2'd3:       amp = AMP_FULL;
        default:    amp = 8'd0;
      endcase
    end
  end

  assign win_end  = (win_q == WIN_LAST);
  assign hits_inc = hits_q + HW'(wave_q);
  assign prod     = PW'(hits_inc) * PW'(amp);

  always_comb begin
    win_d    = win_q + LW'(1);
    hits_d   = hits_inc;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (win_end) begin
      hits_d   = '0;
      sample_d = 8'(prod >> LW);
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q      <= '0;
      stage_preset_q <= '0;
      stage_pivot_q  <= '0;
      act_preset_q   <= '0;
      act_pivot_q    <= '0;
      pending_q      <= 1'b0;
      wave_q         <= 1'b0;
      pend_q         <= 1'b0;
      sample_q       <= '0;
      valid_q        <= 1'b0;
      win_q          <= '0;
      hits_q         <= '0;
    end else begin
      counter_q      <= counter_d;
      stage_preset_q <= stage_preset_d;
      stage_pivot_q  <= stage_pivot_d;
      act_preset_q   <= act_preset_d;
      act_pivot_q    <= act_pivot_d;
      pending_q      <= pending_d;
      wave_q         <= wave_d;
      pend_q         <= pend_d;
      sample_q       <= sample_d;
      valid_q        <= valid_d;
      win_q          <= win_d;
      hits_q         <= hits_d;
    end
  end

  assign snd.wave_out     = wave_q;
  assign snd.period_end   = pend_q;
  assign snd.sample       = sample_q;
  assign snd.sample_valid = valid_q;
endmodule

// File: tb/tb_sound_wave_sequencer.sv
// Directed bench for sound_wave_sequencer: wave timing,
// reload staging, volume gating, decimation and async reset.
module tb_sound_wave_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  sound_wave_sequencer_if snd ();

  sound_wave_sequencer #(
    .SAMPLE_DIV(64),
    .AMP_FULL  (8'd255),
    .AMP_HALF  (8'd128)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .snd  (snd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!snd.sample_valid && n < 300);
    if (!snd.sample_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sv_timeout: no sample_valid in %0d clks", n);
    end
  endtask

  task automatic wait_pe();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!snd.period_end && n < 100);
    if (!snd.period_end) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pe_timeout: no period_end in %0d clks", n);
    end
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    snd.timer_tick    = 1'b0;
    snd.timer_run     = 1'b0;
    snd.preset        = '0;
    snd.pivot         = '0;
    snd.preset_load   = 1'b0;
    snd.sound_control = '0;
    snd.sound_volume  = '0;
    reset = 1'b1;
    #12;
    obs = {snd.wave_out, snd.period_end, snd.sample, snd.sample_valid};
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wave();
    logic exp_w [4];
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b1};
    snd.preset      = 16'd3;
    snd.pivot       = 16'd2;
    snd.preset_load = 1'b1;
    snd.timer_run   = 1'b0;
    step();
    snd.preset_load = 1'b0;
    snd.timer_run   = 1'b1;
    snd.timer_tick  = 1'b1;
    wait_pe();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (snd.wave_out !== exp_w[k]) begin
        n_bad++;
        $display("FAIL wave_%0d: got %b want %b", k, snd.wave_out, exp_w[k]);
      end
      n_cmp++;
      if (snd.period_end !== (k == 3)) begin
        n_bad++;
        $display("FAIL pe_%0d: got %b want %b", k, snd.period_end, k == 3);
      end
    end
  endtask

  task automatic test_volume();
    int n;
    snd.sound_volume  = 3'd3;
    snd.sound_control = 3'd0;
    wait_sv(n);
    wait_sv(n);
    n_cmp++;
    if (n !== 64) begin
      n_bad++;
      $display("FAIL sv_interval: got %0d want 64", n);
    end
    n_cmp++;
    if (snd.sample !== 8'd127) begin
      n_bad++;
      $display("FAIL vol3_half_duty: got %0d want 127", snd.sample);
    end
    snd.sound_volume = 3'd1;
    step();
    n_cmp++;
    if (snd.sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sv_one_clk: got %b want 0", snd.sample_valid);
    end
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd64) begin
      n_bad++;
      $display("FAIL vol1: got %0d want 64", snd.sample);
    end
    snd.sound_volume = 3'd4;
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd0) begin
      n_bad++;
      $display("FAIL vol0: got %0d want 0", snd.sample);
    end
    snd.sound_volume  = 3'd3;
    snd.sound_control = 3'd1;
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd0) begin
      n_bad++;
      $display("FAIL ctrl_mute: got %0d want 0", snd.sample);
    end
    snd.sound_control = 3'd4;
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd127) begin
      n_bad++;
      $display("FAIL ctrl_bit2_ignored: got %0d want 127", snd.sample);
    end
  endtask

  task automatic test_mid_load();
    int idx;
    wait_pe();
    step();
    snd.preset      = 16'd7;
    snd.pivot       = 16'd2;
    snd.preset_load = 1'b1;
    step();
    snd.preset_load = 1'b0;
    n_cmp++;
    if (snd.period_end !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_load_c1: got %b want 0", snd.period_end);
    end
    step();
    n_cmp++;
    if (snd.period_end !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_load_c0: got %b want 0", snd.period_end);
    end
    step();
    n_cmp++;
    if (snd.period_end !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load_reload: got %b want 1", snd.period_end);
    end
    idx = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (snd.period_end && idx == 0) idx = i;
    end
    n_cmp++;
    if (idx !== 8) begin
      n_bad++;
      $display("FAIL period7_len: got %0d want 8", idx);
    end
    // Realign on a reload, then walk to counter==0.
    wait_pe();
    for (int i = 0; i < 7; i++) step();
    snd.preset      = 16'd3;
    snd.pivot       = 16'd2;
    snd.preset_load = 1'b1;
    step();
    snd.preset_load = 1'b0;
    n_cmp++;
    if (snd.period_end !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_reload: got %b want 1", snd.period_end);
    end
    idx = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (snd.period_end && idx == 0) idx = i;
    end
    n_cmp++;
    if (idx !== 4) begin
      n_bad++;
      $display("FAIL bypass_len: got %0d want 4", idx);
    end
  endtask

  task automatic test_pivot_full();
    int n;
    snd.sound_volume  = 3'd3;
    snd.sound_control = 3'd0;
    snd.preset        = 16'd10;
    snd.pivot         = 16'hFFFF;
    snd.preset_load   = 1'b1;
    snd.timer_run     = 1'b0;
    step();
    snd.preset_load = 1'b0;
    snd.timer_run   = 1'b1;
    wait_sv(n);
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd255) begin
      n_bad++;
      $display("FAIL full_duty: got %0d want 255", snd.sample);
    end
    n_cmp++;
    if (snd.wave_out !== 1'b1) begin
      n_bad++;
      $display("FAIL wave_high: got %b want 1", snd.wave_out);
    end
    snd.timer_run = 1'b0;
    step();
    n_cmp++;
    if (snd.wave_out !== 1'b0) begin
      n_bad++;
      $display("FAIL run_drop_wave: got %b want 0", snd.wave_out);
    end
    wait_sv(n);
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd0) begin
      n_bad++;
      $display("FAIL run_drop_sample: got %0d want 0", snd.sample);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [10:0] obs;
    snd.timer_run = 1'b1;
    wait_sv(n);
    wait_sv(n);
    n_cmp++;
    if (snd.sample !== 8'd255) begin
      n_bad++;
      $display("FAIL pre_reset_sample: got %0d want 255", snd.sample);
    end
    for (int i = 0; i < 10; i++) step();
    #2;
    reset = 1'b1;
    #1;
    obs = {snd.wave_out, snd.period_end, snd.sample, snd.sample_valid};
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_sv(n);
    n_cmp++;
    if (n !== 64) begin
      n_bad++;
      $display("FAIL post_reset_window: got %0d want 64", n);
    end
    n_cmp++;
    if (snd.sample !== 8'd0) begin
      n_bad++;
      $display("FAIL post_reset_sample: got %0d want 0", snd.sample);
    end
  endtask

  initial begin
    test_reset();
    test_wave();
    test_volume();
    test_mid_load();
    test_pivot_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end
endmodule
